s_axi_intc_v2: RTL and testbench

Parametrised AXI4-Lite interrupt controller, successor to the single-mode interrupt block. It aggregates NUM_OF_INTR external sources and adds several features:
- per-source edge/level mode
- sticky status with write-1-to-clear acknowledge
- software trigger
- lowest-index vector register
- registered irq output
- independent AW/W acceptance
- SLVERR on unmapped offsets

It sits between the AXI4-Lite interconnect and the processor interrupt input.

---
 rtl/s_axi_intc_pkg.sv | 23 ++
 rtl/s_axi_intc_v2_if.sv | 39 +++
 rtl/intc_prio_enc.sv | 20 ++
 rtl/s_axi_intc_v2.sv | 155 +++++++++++++++
 tb/tb_s_axi_intc_v2.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/s_axi_intc_pkg.sv
// Shared constants for the AXI4-Lite interrupt controller: register codes
// (byte address bits [4:2]), response encodings and the byte-lane mask helper.
package s_axi_intc_pkg;

  localparam logic [2:0] REG_GIE  = 3'd0;
  localparam logic [2:0] REG_IER  = 3'd1;
  localparam logic [2:0] REG_ISR  = 3'd2;
  localparam logic [2:0] REG_IAR  = 3'd3;
  localparam logic [2:0] REG_IPR  = 3'd4;
  localparam logic [2:0] REG_ITR  = 3'd5;
  localparam logic [2:0] REG_ISET = 3'd6;
  localparam logic [2:0] REG_IVR  = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MAX_INTR = 32;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/s_axi_intc_v2_if.sv
// AXI4-Lite bus bundle for the interrupt controller; slave side is the
// controller, master side is the interconnect (or a testbench driver).
interface s_axi_intc_v2_if #(parameter int ADDR_WIDTH = 6) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/intc_prio_enc.sv
// Lowest-index priority encoder: o_idx is the position of the lowest set
// request bit (0 when none), o_valid flags that any request is set.
module intc_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [4:0]   o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = 5'(i);
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/s_axi_intc_v2.sv
// AXI4-Lite interrupt controller: per-source edge/level capture into a sticky
// ISR, W1C/W1S access, lowest-index vector and a registered irq output.
module s_axi_intc_v2
  import s_axi_intc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int NUM_OF_INTR = 8
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_areset,
  s_axi_intc_v2_if.slave         s_axi,
  input  logic [NUM_OF_INTR-1:0] ext_interrupt,
  output logic                   irq
);

  localparam logic [31:0] SRC_MASK = (NUM_OF_INTR >= MAX_INTR) ? 32'hFFFF_FFFF
                                   : ((32'd1 << NUM_OF_INTR) - 32'd1);

  logic                   r_aw_held, r_w_held, r_bvalid, r_rvalid, r_irq, r_gie;
  logic [ADDR_WIDTH-1:0]  r_aw_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [3:0]             r_wstrb;
  logic [1:0]             r_bresp, r_rresp;
  logic [31:0]            r_rdata, r_ier, r_isr, r_itr;
  logic [NUM_OF_INTR-1:0] r_ext_q;

  logic        w_awready, w_wready, w_arready;
  logic        w_commit, w_wr_mapped, w_wr_en;
  logic [2:0]  w_wr_sel;
  logic [31:0] w_bmask, w_wr_bits, w_ext, w_ext_q, w_hw_set, w_sw_set, w_sw_clr;
  logic [31:0] w_isr_nxt, w_ipr, w_rd_data;
  logic [1:0]  w_rd_resp;
  logic        w_ivr_valid;
  logic [4:0]  w_ivr_idx;
  logic        w_unused;

  assign w_awready = ~r_aw_held & ~r_bvalid;
  assign w_wready  = ~r_w_held & ~r_bvalid;
  assign w_arready = ~r_rvalid;

  assign w_commit    = r_aw_held & r_w_held;
  assign w_wr_mapped = ~|r_aw_addr[ADDR_WIDTH-1:5];
  assign w_wr_en     = w_commit & w_wr_mapped;
  assign w_wr_sel    = r_aw_addr[4:2];
  assign w_bmask     = strb_mask(r_wstrb);
  assign w_wr_bits   = r_wdata & w_bmask;

  // Level sources set while high; edge sources only on a 0->1 step.
  assign w_ext     = 32'(ext_interrupt);
  assign w_ext_q   = 32'(r_ext_q);
  assign w_hw_set  = w_ext & (~r_itr | ~w_ext_q);
  assign w_sw_set  = (w_wr_en && w_wr_sel == REG_ISET) ? w_wr_bits : 32'h0;
  assign w_sw_clr  = (w_wr_en && w_wr_sel == REG_IAR)  ? w_wr_bits : 32'h0;
  assign w_isr_nxt = ((r_isr & ~w_sw_clr) | w_hw_set | w_sw_set) & SRC_MASK;
  assign w_ipr     = r_isr & r_ier;

  intc_prio_enc #(.N(NUM_OF_INTR)) u_prio (
    .i_req   (w_ipr[NUM_OF_INTR-1:0]),
    .o_valid (w_ivr_valid),
    .o_idx   (w_ivr_idx)
  );

  always_comb begin
    w_rd_data = 32'h0;
    w_rd_resp = RESP_OKAY;
    if (|s_axi.araddr[ADDR_WIDTH-1:5]) begin
      w_rd_resp = RESP_SLVERR;
    end else begin
      case (s_axi.araddr[4:2])
        REG_GIE: w_rd_data = {31'h0, r_gie};
        REG_IER: w_rd_data = r_ier;
        REG_ISR: w_rd_data = r_isr;
        REG_IPR: w_rd_data = w_ipr;
        REG_ITR: w_rd_data = r_itr;
        REG_IVR: w_rd_data = {w_ivr_valid, 26'h0, w_ivr_idx};
        default: w_rd_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_gie     <= 1'b0;
      r_ier     <= '0;
      r_isr     <= '0;
      r_itr     <= '0;
      r_ext_q   <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_ext_q <= ext_interrupt;
      r_isr   <= w_isr_nxt;
      r_irq   <= r_gie & (|w_ipr);

      if (s_axi.awvalid && w_awready) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axi.awaddr;
      end
      if (s_axi.wvalid && w_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi.wdata;
        r_wstrb  <= s_axi.wstrb;
      end

      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s_axi.bready) begin
        r_bvalid <= 1'b0;
      end

      if (w_wr_en) begin
        case (w_wr_sel)
          REG_GIE: r_gie <= (r_gie & ~w_bmask[0]) | w_wr_bits[0];
          REG_IER: r_ier <= ((r_ier & ~w_bmask) | w_wr_bits) & SRC_MASK;
          REG_ITR: r_itr <= ((r_itr & ~w_bmask) | w_wr_bits) & SRC_MASK;
          default: ;
        endcase
      end

      if (s_axi.arvalid && w_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_resp;
      end else if (r_rvalid && s_axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.arready = w_arready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign irq           = r_irq;

  assign w_unused = ^{s_axi.awprot, s_axi.arprot, r_aw_addr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_s_axi_intc_v2.sv
// Scoreboard bench for s_axi_intc_v2: a register-level reference model predicts
// handshakes, responses and irq; a negedge monitor compares against the DUT.
module tb_s_axi_intc_v2;
  localparam int NI = 8;
  localparam logic [31:0] SRC = (NI == 32) ? 32'hFFFF_FFFF : ((32'd1 << NI) - 32'd1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] ext = '0;
  logic          irq;

  s_axi_intc_v2_if #(.ADDR_WIDTH(6)) axi ();

  s_axi_intc_v2 #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_OF_INTR(NI)) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .s_axi         (axi),
    .ext_interrupt (ext),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  // Reference model state: architectural registers plus the bus holding flags.
  logic          m_gie;
  logic [31:0]   m_ier, m_isr, m_itr, m_wd;
  logic [NI-1:0] m_extq;
  logic          m_irq, m_awh, m_wh, m_bv, m_rv;
  logic [5:0]    m_aa;
  logic [3:0]    m_ws;

  function automatic void chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk34(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void tmo(input string nm, input int n);
    n_tests++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL %s: waited %0d cycles, limit 50", nm, n);
    end
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [33:0] exp_read(input logic [5:0] a);
    logic [31:0] p = m_isr & m_ier;
    logic [31:0] d = 32'h0;
    if (a >= 6'h20) return {2'b10, 32'h0};
    case (int'(a) / 4)
      0: d = {31'h0, m_gie};
      1: d = m_ier;
      2: d = m_isr;
      4: d = p;
      5: d = m_itr;
      7: begin
        for (int i = 0; i < NI; i++) begin
          if (p[i]) begin
            d = 32'h8000_0000 | 32'(i);
            break;
          end
        end
      end
      default: d = 32'h0;
    endcase
    return {2'b00, d};
  endfunction

  task automatic model_step();
    logic [31:0] setm, clr, sws, bm, wv;
    logic aw_hs, w_hs, ar_hs, irq_n;
    if (rst) begin
      m_gie = 0; m_ier = 0; m_isr = 0; m_itr = 0; m_extq = 0; m_irq = 0;
      m_awh = 0; m_wh = 0; m_bv = 0; m_rv = 0; m_aa = 0; m_wd = 0; m_ws = 0;
      rq.delete();
      bq.delete();
    end else begin
      aw_hs = axi.awvalid && !m_awh && !m_bv;
      w_hs  = axi.wvalid && !m_wh && !m_bv;
      ar_hs = axi.arvalid && !m_rv;
      irq_n = m_gie && ((m_isr & m_ier) != 32'h0);
      if (ar_hs) rq.push_back(exp_read(axi.araddr));
      if (ar_hs) m_rv = 1;
      else if (axi.rready) m_rv = 0;
      setm = 0; clr = 0; sws = 0;
      for (int i = 0; i < NI; i++) setm[i] = m_itr[i] ? (ext[i] && !m_extq[i]) : ext[i];
      if (m_awh && m_wh) begin
        bm = lanes(m_ws);
        wv = m_wd & bm;
        if (m_aa >= 6'h20) bq.push_back(2'b10);
        else begin
          bq.push_back(2'b00);
          case (int'(m_aa) / 4)
            0: if (bm[0]) m_gie = wv[0];
            1: m_ier = ((m_ier & ~bm) | wv) & SRC;
            3: clr = wv;
            5: m_itr = ((m_itr & ~bm) | wv) & SRC;
            6: sws = wv;
            default: ;
          endcase
        end
        m_awh = 0; m_wh = 0; m_bv = 1;
      end else if (axi.bready) m_bv = 0;
      m_isr  = ((m_isr & ~clr) | setm | sws) & SRC;
      m_extq = ext;
      m_irq  = irq_n;
      if (aw_hs) begin m_awh = 1; m_aa = axi.awaddr; end
      if (w_hs) begin m_wh = 1; m_wd = axi.wdata; m_ws = axi.wstrb; end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk1("awready", axi.awready, !m_awh && !m_bv);
      chk1("wready",  axi.wready,  !m_wh && !m_bv);
      chk1("arready", axi.arready, !m_rv);
      chk1("bvalid",  axi.bvalid,  m_bv);
      chk1("rvalid",  axi.rvalid,  m_rv);
      chk1("irq",     irq,         m_irq);
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) chk34("bresp_unexpected", {32'h0, axi.bresp}, 34'h3_FFFF_FFFF);
        else chk34("bresp", {32'h0, axi.bresp}, {32'h0, bq.pop_front()});
      end
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) chk34("read_unexpected", {axi.rresp, axi.rdata}, 34'h3_FFFF_FFFF);
        else chk34("read", {axi.rresp, axi.rdata}, rq.pop_front());
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    logic awf, wf;
    axi.awaddr = a; axi.awvalid = 1;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1;
    while ((axi.awvalid || axi.wvalid) && n < 50) begin
      awf = axi.awvalid && axi.awready;
      wf  = axi.wvalid && axi.wready;
      cyc(1);
      n++;
      if (awf) axi.awvalid = 0;
      if (wf) axi.wvalid = 0;
    end
    axi.awvalid = 0; axi.wvalid = 0;
    tmo("aw_w_accept", n);
    n = 0;
    while (!(axi.bvalid && axi.bready) && n < 50) begin cyc(1); n++; end
    tmo("b_resp_wait", n);
    cyc(1);
  endtask

  task automatic rd(input logic [5:0] a);
    int n = 0;
    axi.araddr = a; axi.arvalid = 1;
    while (!axi.arready && n < 50) begin cyc(1); n++; end
    cyc(1);
    axi.arvalid = 0;
    tmo("ar_accept", n);
    n = 0;
    while (!(axi.rvalid && axi.rready) && n < 50) begin cyc(1); n++; end
    tmo("r_resp_wait", n);
    cyc(1);
  endtask

  function automatic logic [5:0] raddr();
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(32, 63));
    return 6'($urandom_range(0, 31));
  endfunction

  initial begin
    int n;
    logic awf, wf, arf;
    logic [31:0] r;
    axi.awaddr = 0; axi.awprot = 0; axi.awvalid = 0;
    axi.wdata = 0; axi.wstrb = 0; axi.wvalid = 0; axi.bready = 1;
    axi.araddr = 0; axi.arprot = 0; axi.arvalid = 0; axi.rready = 1;
    rst = 1;
    cyc(3);
    chk_en = 1;
    cyc(1);
    rst = 0;

    for (int a = 0; a <= 32; a += 4) rd(6'(a));

    wr(6'h04, 32'h5, 4'hF);
    wr(6'h00, 32'h1, 4'hF);
    ext = 8'h04; cyc(1); ext = 0; cyc(3);
    rd(6'h08); rd(6'h10); rd(6'h1C);
    wr(6'h0C, 32'h4, 4'hF);
    rd(6'h08); cyc(2);

    wr(6'h14, 32'h1, 4'hF);
    ext = 8'h01; cyc(10);
    rd(6'h08);
    wr(6'h0C, 32'h1, 4'hF);
    rd(6'h08);
    wr(6'h14, 32'h0, 4'hF);
    wr(6'h0C, 32'h1, 4'hF);
    rd(6'h08);
    ext = 0;
    wr(6'h0C, 32'hFF, 4'hF);

    axi.bready = 0;
    axi.wdata = 32'h3; axi.wstrb = 4'hF; axi.wvalid = 1;
    cyc(1); axi.wvalid = 0;
    cyc(2);
    axi.awaddr = 6'h04; axi.awvalid = 1;
    cyc(1); axi.awvalid = 0;
    cyc(6);
    axi.bready = 1;
    cyc(2);

    wr(6'h04, 32'hFFFF_FFFF, 4'h1);
    rd(6'h04);
    wr(6'h18, 32'h30, 4'hF);
    wr(6'h04, 32'h20, 4'hF);
    rd(6'h1C);
    wr(6'h08, 32'hFF, 4'hF);
    wr(6'h24, 32'hFF, 4'hF);
    rd(6'h08);

    ext = 8'h02;
    wr(6'h0C, 32'h2, 4'hF);
    rd(6'h08);
    ext = 0;

    wr(6'h04, 32'h55, 4'hF);
    axi.bready = 0;
    axi.awaddr = 6'h04; axi.awvalid = 1;
    axi.wdata = 32'hAA; axi.wstrb = 4'hF; axi.wvalid = 1;
    cyc(1); axi.awvalid = 0; axi.wvalid = 0;
    n = 0;
    while (!axi.bvalid && n < 50) begin cyc(1); n++; end
    tmo("b_before_reset", n);
    rst = 1; cyc(1); rst = 0; axi.bready = 1;
    cyc(1);
    rd(6'h04);

    awf = 0; wf = 0; arf = 0;
    for (int c = 0; c < 3000; c++) begin
      if (awf) axi.awvalid = 0;
      if (wf) axi.wvalid = 0;
      if (arf) axi.arvalid = 0;
      if (!axi.awvalid && $urandom_range(0, 3) == 0) begin
        axi.awvalid = 1; axi.awaddr = raddr();
      end
      if (!axi.wvalid && $urandom_range(0, 3) == 0) begin
        axi.wvalid = 1; axi.wdata = $urandom; axi.wstrb = 4'($urandom);
      end
      if (!axi.arvalid && $urandom_range(0, 2) == 0) begin
        axi.arvalid = 1; axi.araddr = raddr();
      end
      axi.bready = ($urandom_range(0, 3) != 0);
      axi.rready = ($urandom_range(0, 3) != 0);
      r = $urandom & $urandom & $urandom;
      ext = r[NI-1:0];
      awf = axi.awvalid && axi.awready;
      wf  = axi.wvalid && axi.wready;
      arf = axi.arvalid && axi.arready;
      cyc(1);
    end
    if (awf) axi.awvalid = 0;
    if (wf) axi.wvalid = 0;
    if (arf) axi.arvalid = 0;
    n = 0;
    while ((axi.awvalid || axi.wvalid || axi.arvalid) && n < 50) begin
      awf = axi.awvalid && axi.awready;
      wf  = axi.wvalid && axi.wready;
      arf = axi.arvalid && axi.arready;
      axi.bready = 1; axi.rready = 1;
      cyc(1);
      n++;
      if (awf) axi.awvalid = 0;
      if (wf) axi.wvalid = 0;
      if (arf) axi.arvalid = 0;
    end
    tmo("random_drain", n);
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    axi.bready = 1; axi.rready = 1; ext = 0;
    cyc(10);
    chk34("rq_drained", 34'(rq.size()), 34'd0);
    chk34("bq_drained", 34'(bq.size()), 34'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
